// File: rtl/soundrive_pkg.sv
// Shared constants for the buffered Soundrive/Covox DAC front-end.
// Port map and idle DAC level used by soundrive_fifo and its bench.
package soundrive_pkg;

    localparam logic [7:0] SD_PORT [0:3] = '{8'h0F, 8'h1F, 8'h4F, 8'h5F};
    localparam logic [7:0] COVOX_PORT    = 8'hFB;
    localparam logic [7:0] STATUS_PORT   = 8'h3F;
    localparam logic [7:0] DAC_IDLE      = 8'h80;
    localparam int         MAX_CH        = 4;

endpackage

// File: rtl/cpu_bus.sv
// CPU I/O bus shared by the peripherals.
// The CPU side drives everything; peripherals only observe.
interface cpu_bus;

    logic        ioreq;
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;

    modport master (output ioreq, rd, wr, a, d);
    modport periph (input  ioreq, rd, wr, a, d);

endinterface

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with wrap-bit pointers, all DEPTH entries usable.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module sample_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wp_q;
    logic [AW:0]       wp_d;
    logic [AW:0]       rp_q;
    logic [AW:0]       rp_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty_o = (wp_q == rp_q);
    assign full_o  = (wp_q[AW] != rp_q[AW]) &&
                     (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign dout_o  = mem_q[rp_q[AW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign wp_d = wp_q + {{AW{1'b0}}, do_push};
    assign rp_d = rp_q + {{AW{1'b0}}, do_pop};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end

    // On full+pop the write slot is the one being read; dout is taken pre-edge.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wp_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/soundrive_fifo.sv
// Buffered Soundrive/Covox DAC: OUT writes fill per-channel FIFOs, replayed at a fixed rate.
// Optional status port 0x3F and overflow flags under SOUNDRIVE_FIFO_STATUS_EN.
module soundrive_fifo #(
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 16,
    parameter int DATA_W   = 8,
    parameter int RATE_DIV = 635
) (
    input  logic                             clk28,
    input  logic                             rst,
    input  logic                             en_soundrive,
    input  logic                             en_covox,
    cpu_bus.periph                           bus,
    output logic [CHANNELS-1:0][DATA_W-1:0]  ch,
    output logic [7:0]                       d_out,
    output logic                             d_out_active
);

    import soundrive_pkg::*;

    localparam int DIV_W = $clog2(RATE_DIV);

    logic [DIV_W-1:0]                 div_q;
    logic [DIV_W-1:0]                 div_d;
    logic                             tick;
    logic [CHANNELS-1:0]              wr_hit;
    logic [CHANNELS-1:0]              wr_hit_q;
    logic [CHANNELS-1:0]              push;
    logic [CHANNELS-1:0]              pop;
    logic [CHANNELS-1:0]              full;
    logic [CHANNELS-1:0]              empty;
    logic [CHANNELS-1:0][DATA_W-1:0]  fifo_dout;
    logic [CHANNELS-1:0][DATA_W-1:0]  ch_q;
    logic [CHANNELS-1:0][DATA_W-1:0]  ch_d;
    logic [DATA_W-1:0]                wdata;

    assign tick  = (div_q == DIV_W'(RATE_DIV - 1));
    assign wdata = bus.d[DATA_W-1:0];
    assign push  = wr_hit & ~wr_hit_q;
    assign ch    = ch_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign wr_hit[i] = bus.ioreq && bus.wr &&
            ((en_soundrive && bus.a[7:0] == SD_PORT[i]) ||
             (en_covox && bus.a[7:0] == COVOX_PORT));
        assign pop[i] = tick && !empty[i];

        sample_fifo #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W)
        ) u_fifo (
            .clk_i   (clk28),
            .rst_i   (rst),
            .push_i  (push[i]),
            .pop_i   (pop[i]),
            .din_i   (wdata),
            .dout_o  (fifo_dout[i]),
            .full_o  (full[i]),
            .empty_o (empty[i])
        );
    end

    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
        ch_d  = ch_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (pop[i]) begin
                ch_d[i] = fifo_dout[i];
            end
        end
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            div_q    <= '0;
            wr_hit_q <= '0;
            ch_q     <= {CHANNELS{DATA_W'(DAC_IDLE)}};
        end else begin
            div_q    <= div_d;
            wr_hit_q <= wr_hit;
            ch_q     <= ch_d;
        end
    end

`ifdef SOUNDRIVE_FIFO_STATUS_EN
    logic                rd_hit;
    logic                rd_hit_q;
    logic                rd_fall;
    logic [CHANNELS-1:0] ovf_q;
    logic [CHANNELS-1:0] ovf_d;
    logic [3:0]          ovf4;
    logic [3:0]          emp4;

    assign rd_hit  = (en_soundrive || en_covox) && bus.ioreq && bus.rd &&
                     (bus.a[7:0] == STATUS_PORT);
    assign rd_fall = rd_hit_q && !rd_hit;
    // A fresh overflow wins over the clear that ends the read.
    assign ovf_d   = (rd_fall ? '0 : ovf_q) | (push & full & ~pop);
    assign ovf4    = 4'(ovf_q);
    assign emp4    = 4'(empty);

    assign d_out        = rd_hit ? {ovf4, emp4} : 8'h00;
    assign d_out_active = rd_hit;

    always_ff @(posedge clk28) begin
        if (rst) begin
            rd_hit_q <= 1'b0;
            ovf_q    <= '0;
        end else begin
            rd_hit_q <= rd_hit;
            ovf_q    <= ovf_d;
        end
    end

    wire unused_bits = ^{bus.a[15:8], bus.d};
`else
    assign d_out        = 8'h00;
    assign d_out_active = 1'b0;

    wire unused_bits = ^{bus.a[15:8], bus.d, bus.rd, full};
`endif

endmodule
